// File: rtl/memory_if.sv
// Bus between the A09 CPU and its program/data RAM; enables are active-low.
// Signal names follow the A09 control-bus naming used by the CPU side.
interface memory_if #(
    parameter int Data_WIDTH    = 16,
    parameter int Address_WIDTH = 8
);
    logic [Data_WIDTH-1:0]    DIn;
    logic [Address_WIDTH-1:0] Address;
    logic                     Write_EN;
    logic                     Mem_En;
    logic [Data_WIDTH-1:0]    DOut;

    modport master (
        output DIn,
        output Address,
        output Write_EN,
        output Mem_En,
        input  DOut
    );

    modport slave (
        input  DIn,
        input  Address,
        input  Write_EN,
        input  Mem_En,
        output DOut
    );
endinterface

// File: rtl/memory.sv
// Single-port A09 program/data RAM, accessed on the falling edge of Clk with write-through.
// Define MEMORY_PRELOAD_EN to start with the boot program image instead of all zeros.
module memory #(
    parameter int Data_WIDTH    = 16,
    parameter int Address_WIDTH = 8
) (
    input  logic     Clk,
    input  logic     Reset_N,
    memory_if.slave  bus
);
    localparam int DEPTH = 1 << Address_WIDTH;

    // NOTE: the array has no reset term; contents must survive Reset_N, and a
    // reset loop over every word would also prevent mapping onto a RAM macro.
`ifdef MEMORY_PRELOAD_EN
    logic [Data_WIDTH-1:0] mem_q [DEPTH] = '{
        0:       Data_WIDTH'(16'h9202),
        1:       Data_WIDTH'(16'h9304),
        2:       Data_WIDTH'(16'h2621),
        3:       Data_WIDTH'(16'h1000),
        default: '0
    };
`else
    logic [Data_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
`endif

    logic [Data_WIDTH-1:0] dout_q;
    logic [Data_WIDTH-1:0] dout_d;
    logic                  wr_en;
    logic                  rd_en;

    assign wr_en = (bus.Mem_En == 1'b0) && (bus.Write_EN == 1'b0);
    assign rd_en = (bus.Mem_En == 1'b0) && (bus.Write_EN == 1'b1);

    // NOTE: dout_d takes its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
        dout_d = dout_q;
        if (wr_en) begin
            dout_d = bus.DIn;
        end else if (rd_en) begin
            dout_d = mem_q[bus.Address];
        end
    end

    // Writes are deliberately outside the reset block: they still land while Reset_N is low.
    // NOTE: sequential state is updated with <= so all falling-edge updates see pre-edge values.
    always_ff @(negedge Clk) begin
        if (wr_en) begin
            mem_q[bus.Address] <= bus.DIn;
        end
    end

    always_ff @(negedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign bus.DOut = dout_q;
endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the A09 RAM: directed scenarios plus random traffic against an array model.
module tb_memory;
    logic Clk;
    logic Reset_N;
    int   checks;
    int   failures;

    logic [15:0] ref_mem [256];
    logic [15:0] ref_dout;

    memory_if #(.Data_WIDTH(16), .Address_WIDTH(8)) bus ();

    memory #(.Data_WIDTH(16), .Address_WIDTH(8)) dut (
        .Clk     (Clk),
        .Reset_N (Reset_N),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #100 Clk = ~Clk;

    // Reference behaviour: one access as the CPU sees it at a falling edge.
    function automatic void ref_access(input logic en_n, input logic we_n,
                                       input logic [7:0] a, input logic [15:0] d);
        if (en_n == 1'b0) begin
            if (we_n == 1'b0) begin
                ref_mem[a] = d;
                ref_dout   = d;
            end else begin
                ref_dout = ref_mem[a];
            end
        end
    endfunction

    // Drive 10 ns before the next falling edge, return 10 ns after it.
    task automatic drive(input logic en_n, input logic we_n,
                         input logic [7:0] a, input logic [15:0] d);
        @(posedge Clk);
        #90;
        bus.Mem_En   = en_n;
        bus.Write_EN = we_n;
        bus.Address  = a;
        bus.DIn      = d;
        @(negedge Clk);
        #10;
    endtask

    task automatic test_reset();
        Reset_N      = 1'b1;
        bus.Mem_En   = 1'b1;
        bus.Write_EN = 1'b1;
        bus.Address  = '0;
        bus.DIn      = '0;
        #1 Reset_N = 1'b0;
        ref_dout = 16'h0000;
        #19;
        checks++;
        if (bus.DOut !== ref_dout) begin
            failures++;
            $display("FAIL reset_dout: got %h expected %h", bus.DOut, ref_dout);
        end
        #30 Reset_N = 1'b1;
    endtask

    task automatic test_preload_reads();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'(i), 16'h0000);
            ref_access(1'b0, 1'b1, 8'(i), 16'h0000);
            checks++;
            if (bus.DOut !== ref_dout) begin
                failures++;
                $display("FAIL preload_read[%0d]: got %h expected %h", i, bus.DOut, ref_dout);
            end
        end
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b0, 8'h0A, 16'h0666);
        ref_access(1'b0, 1'b0, 8'h0A, 16'h0666);
        checks++;
        if (bus.DOut !== 16'h0666) begin
            failures++;
            $display("FAIL write_through: got %h expected %h", bus.DOut, 16'h0666);
        end
        drive(1'b0, 1'b1, 8'h0A, 16'h0000);
        ref_access(1'b0, 1'b1, 8'h0A, 16'h0000);
        checks++;
        if (bus.DOut !== 16'h0666) begin
            failures++;
            $display("FAIL read_after_write: got %h expected %h", bus.DOut, 16'h0666);
        end
    endtask

    task automatic test_disabled();
        drive(1'b1, 1'b0, 8'h05, 16'hBEEF);
        checks++;
        if (bus.DOut !== ref_dout) begin
            failures++;
            $display("FAIL disabled_hold: got %h expected %h", bus.DOut, ref_dout);
        end
        drive(1'b1, 1'bx, 8'h06, 16'hDEAD);
        checks++;
        if (bus.DOut !== ref_dout) begin
            failures++;
            $display("FAIL disabled_x_we: got %h expected %h", bus.DOut, ref_dout);
        end
        drive(1'b0, 1'b1, 8'h05, 16'h0000);
        ref_access(1'b0, 1'b1, 8'h05, 16'h0000);
        checks++;
        if (bus.DOut !== 16'h0000) begin
            failures++;
            $display("FAIL disabled_no_write_05: got %h expected %h", bus.DOut, 16'h0000);
        end
        drive(1'b0, 1'b1, 8'h06, 16'h0000);
        ref_access(1'b0, 1'b1, 8'h06, 16'h0000);
        checks++;
        if (bus.DOut !== 16'h0000) begin
            failures++;
            $display("FAIL disabled_no_write_06: got %h expected %h", bus.DOut, 16'h0000);
        end
    endtask

    task automatic test_reset_retention();
        drive(1'b0, 1'b1, 8'h01, 16'h0000);
        ref_access(1'b0, 1'b1, 8'h01, 16'h0000);
        // Mid-cycle pulse: we are 10 ns past a falling edge, so go to mid high phase.
        #140 Reset_N = 1'b0;
        ref_dout = 16'h0000;
        #5;
        checks++;
        if (bus.DOut !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset_clear: got %h expected %h", bus.DOut, 16'h0000);
        end
        #20 Reset_N = 1'b1;
        drive(1'b0, 1'b1, 8'h01, 16'h0000);
        ref_access(1'b0, 1'b1, 8'h01, 16'h0000);
        checks++;
        if (bus.DOut !== ref_dout) begin
            failures++;
            $display("FAIL reset_retains_01: got %h expected %h", bus.DOut, ref_dout);
        end
        // A write issued while reset is held reaches the array but not DOut.
        Reset_N = 1'b0;
        ref_dout = 16'h0000;
        drive(1'b0, 1'b0, 8'h20, 16'h1234);
        ref_mem[8'h20] = 16'h1234;
        checks++;
        if (bus.DOut !== 16'h0000) begin
            failures++;
            $display("FAIL reset_write_dout: got %h expected %h", bus.DOut, 16'h0000);
        end
        Reset_N = 1'b1;
        drive(1'b0, 1'b1, 8'h20, 16'h0000);
        ref_access(1'b0, 1'b1, 8'h20, 16'h0000);
        checks++;
        if (bus.DOut !== ref_dout) begin
            failures++;
            $display("FAIL reset_write_array: got %h expected %h", bus.DOut, ref_dout);
        end
    endtask

    task automatic test_edge_sensitivity();
        drive(1'b0, 1'b1, 8'h02, 16'h0000);
        ref_access(1'b0, 1'b1, 8'h02, 16'h0000);
        @(posedge Clk);
        #1;
        bus.Address = 8'h00;
        #50;
        checks++;
        if (bus.DOut !== ref_dout) begin
            failures++;
            $display("FAIL rising_edge_no_effect: got %h expected %h", bus.DOut, ref_dout);
        end
        @(negedge Clk);
        #10;
        ref_access(1'b0, 1'b1, 8'h00, 16'h0000);
        checks++;
        if (bus.DOut !== ref_dout) begin
            failures++;
            $display("FAIL falling_edge_update: got %h expected %h", bus.DOut, ref_dout);
        end
    endtask

    task automatic test_top_address();
        drive(1'b0, 1'b0, 8'hFF, 16'hA5A5);
        ref_access(1'b0, 1'b0, 8'hFF, 16'hA5A5);
        drive(1'b0, 1'b1, 8'hFF, 16'h0000);
        ref_access(1'b0, 1'b1, 8'hFF, 16'h0000);
        checks++;
        if (bus.DOut !== 16'hA5A5) begin
            failures++;
            $display("FAIL top_addr_read: got %h expected %h", bus.DOut, 16'hA5A5);
        end
        drive(1'b0, 1'b1, 8'h00, 16'h0000);
        ref_access(1'b0, 1'b1, 8'h00, 16'h0000);
        checks++;
        if (bus.DOut !== ref_dout) begin
            failures++;
            $display("FAIL addr0_untouched: got %h expected %h", bus.DOut, ref_dout);
        end
    endtask

    task automatic test_random();
        logic        en_n;
        logic        we_n;
        logic [7:0]  a;
        logic [15:0] d;
        for (int i = 0; i < 300; i++) begin
            en_n = ($urandom_range(0, 4) == 0);
            we_n = $urandom_range(0, 1) == 1;
            a    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            d    = 16'($urandom);
            drive(en_n, we_n, a, d);
            ref_access(en_n, we_n, a, d);
            checks++;
            if (bus.DOut !== ref_dout) begin
                failures++;
                $display("FAIL random[%0d] en_n=%b we_n=%b addr=%h: got %h expected %h",
                         i, en_n, we_n, a, bus.DOut, ref_dout);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
`ifdef MEMORY_PRELOAD_EN
        ref_mem[0] = 16'h9202;
        ref_mem[1] = 16'h9304;
        ref_mem[2] = 16'h2621;
        ref_mem[3] = 16'h1000;
`endif
        test_reset();
        test_preload_reads();
        test_write_read();
        test_disabled();
        test_reset_retention();
        test_edge_sensitivity();
        test_top_address();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
